// File: rtl/fifo_read_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : fifo_read_unpacker
// Description : Pops whole words from a show-ahead async FIFO read port and
//               serialises each into OWIDTH-wide beats on a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_unpacker #(
    parameter int DWIDTH = 160,
    parameter int OWIDTH = 32,
    parameter int CWIDTH = 16
) (
    input  logic              RCLK,
    input  logic              RRST_n,
    input  logic [DWIDTH-1:0] RDATA,
    input  logic              REMPTY,
    output logic              RINC,
    input  logic              EN,
    output logic [OWIDTH-1:0] ODATA,
    output logic              OVALID,
    input  logic              OREADY,
    output logic              OLAST,
    output logic [CWIDTH-1:0] WORD_CNT
);

    localparam int            BEATS    = DWIDTH / OWIDTH;
    localparam int            IW       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BEATS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t              r_state;
    logic [DWIDTH-1:0]   r_buf;
    logic [IW-1:0]       r_idx;

    logic                w_accept;
    logic                w_load;
    logic [IW-1:0]       w_idx_nxt;
    logic [OWIDTH-1:0]   w_beat_nxt;

    // A new word may be taken while idle, or in the same cycle the final beat
    // of the current word is accepted, giving one beat per cycle sustained.
    assign w_accept  = OVALID & OREADY;
    assign w_load    = EN & ~REMPTY & ((r_state == ST_IDLE) | (w_accept & OLAST));
    assign RINC      = w_load & RRST_n;
    assign w_idx_nxt = r_idx + IW'(1);

    always_comb begin
        w_beat_nxt = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (w_idx_nxt == IW'(b)) begin
                w_beat_nxt = r_buf[b*OWIDTH +: OWIDTH];
            end
        end
    end

    always_ff @(posedge RCLK or negedge RRST_n) begin
        if (!RRST_n) begin
            r_state  <= ST_IDLE;
            r_buf    <= '0;
            r_idx    <= '0;
            ODATA    <= '0;
            OVALID   <= 1'b0;
            OLAST    <= 1'b0;
            WORD_CNT <= '0;
        end else if (w_load) begin
            r_state  <= ST_SEND;
            r_buf    <= RDATA;
            r_idx    <= '0;
            ODATA    <= RDATA[OWIDTH-1:0];
            OVALID   <= 1'b1;
            OLAST    <= (BEATS == 1);
            WORD_CNT <= WORD_CNT + CWIDTH'(1);
        end else if (w_accept) begin
            if (OLAST) begin
                r_state <= ST_IDLE;
                OVALID  <= 1'b0;
                OLAST   <= 1'b0;
            end else begin
                r_idx <= w_idx_nxt;
                ODATA <= w_beat_nxt;
                OLAST <= (w_idx_nxt == LAST_IDX);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_read_unpacker
// Description : Scoreboard bench for fifo_read_unpacker with a queue-based FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_read_unpacker;

    localparam int DW = 160;
    localparam int OW = 32;
    localparam int CW = 16;
    localparam int NB = 5;

    logic          RCLK = 1'b0;
    logic          RRST_n;
    logic [DW-1:0] RDATA = '0;
    logic          REMPTY = 1'b1;
    logic          RINC;
    logic          EN = 1'b0;
    logic [OW-1:0] ODATA;
    logic          OVALID;
    logic          OREADY = 1'b0;
    logic          OLAST;
    logic [CW-1:0] WORD_CNT;

    // narrow-counter instance for the wrap case
    logic [DW-1:0] rdata2 = {5{32'hC0DE_0001}};
    logic          rempty2 = 1'b0;
    logic          en2 = 1'b0;
    logic          oready2 = 1'b1;
    logic          rinc2;
    logic [OW-1:0] odata2;
    logic          ovalid2;
    logic          olast2;
    logic [3:0]    cnt2;

    always #5 RCLK = ~RCLK;

    fifo_read_unpacker #(.DWIDTH(DW), .OWIDTH(OW), .CWIDTH(CW)) u_dut (
        .RCLK(RCLK), .RRST_n(RRST_n), .RDATA(RDATA), .REMPTY(REMPTY),
        .RINC(RINC), .EN(EN), .ODATA(ODATA), .OVALID(OVALID),
        .OREADY(OREADY), .OLAST(OLAST), .WORD_CNT(WORD_CNT)
    );

    fifo_read_unpacker #(.DWIDTH(DW), .OWIDTH(OW), .CWIDTH(4)) u_wrap (
        .RCLK(RCLK), .RRST_n(RRST_n), .RDATA(rdata2), .REMPTY(rempty2),
        .RINC(rinc2), .EN(en2), .ODATA(odata2), .OVALID(ovalid2),
        .OREADY(oready2), .OLAST(olast2), .WORD_CNT(cnt2)
    );

    logic [DW-1:0] fifo_q[$];
    logic [OW:0]   exp_q[$];
    int  npass = 0, ntotal = 0;
    int  pop_cnt = 0, beat_cnt = 0, idle_pop_cnt = 0, bad_pop_cnt = 0;
    int  cyc = 0, pop_cyc = -1, first_beat_cyc = -1, last_beat_cyc = -1;
    bit  pop_pending = 1'b0;
    bit  prev_stall = 1'b0;
    logic [OW-1:0] prev_data;
    logic          prev_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        ntotal++;
        if (act === req) npass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        for (int b = 0; b < NB; b++) exp_q.push_back({(b == NB-1), w[b*OW +: OW]});
    endtask

    task automatic wait_beats(input int target, input int budget);
        int t;
        t = 0;
        while (beat_cnt < target && t < budget) begin
            @(posedge RCLK);
            t++;
        end
        if (beat_cnt < target) check("beat_timeout", beat_cnt, target);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge RCLK);
        #1;
    endtask

    // FIFO model: pops the word the DUT took on this edge, then presents the next
    always @(posedge RCLK) begin
        #2;
        if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
        pop_pending = 1'b0;
        REMPTY = (fifo_q.size() == 0);
        RDATA  = REMPTY ? '0 : fifo_q[0];
    end

    // Monitor: inputs are stable here, so this sees exactly what the next edge sees
    always @(negedge RCLK) begin
        logic [OW:0] e;
        cyc++;
        pop_pending = RINC;
        if (RINC) begin
            pop_cnt++;
            pop_cyc = cyc;
            check("rinc_when_empty", REMPTY, 1'b0);
            if (!OVALID) idle_pop_cnt++;
            else if (!(OREADY && OLAST)) bad_pop_cnt++;
        end
        if (!RRST_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", OVALID, 1'b1);
                check("hold_data", ODATA, prev_data);
                check("hold_last", OLAST, prev_last);
            end
            if (OVALID && OREADY) begin
                beat_cnt++;
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("extra_beat", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", ODATA, e[OW-1:0]);
                    check("beat_last", OLAST, e[OW]);
                end
            end
            prev_stall = OVALID && !OREADY;
            prev_data  = ODATA;
            prev_last  = OLAST;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, p0, ip0, t;

        // ---- 1. reset hold, single word, reset mid-word ----
        RRST_n = 1'b1;
        #1 RRST_n = 1'b0;
        EN = 1'b1;
        OREADY = 1'b1;
        push_word(160'h00000005_00000004_00000003_00000002_00000001);
        for (int i = 0; i < 5; i++) begin
            @(negedge RCLK);
            check("rst_rinc", RINC, 1'b0);
            check("rst_ovalid", OVALID, 1'b0);
            check("rst_cnt", WORD_CNT, 0);
        end
        @(posedge RCLK); #1;
        first_beat_cyc = -1;
        RRST_n = 1'b1;
        wait_beats(5, 40);
        check("t1_pops", pop_cnt, 1);
        check("t1_latency", first_beat_cyc - pop_cyc, 1);
        check("t1_contig", last_beat_cyc - first_beat_cyc, 4);
        check("t1_cnt", WORD_CNT, 1);

        @(posedge RCLK); #1;
        push_word(160'hE5E5E5E5_E4E4E4E4_E3E3E3E3_E2E2E2E2_E1E1E1E1);
        wait_beats(7, 40);
        #3;
        RRST_n = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        pop_pending = 1'b0;
        #1;
        check("arst_ovalid", OVALID, 1'b0);
        check("arst_olast", OLAST, 1'b0);
        check("arst_cnt", WORD_CNT, 0);
        check("arst_rinc", RINC, 1'b0);
        idle_cycles(2);
        RRST_n = 1'b1;
        b0 = beat_cnt;
        idle_cycles(10);
        check("t1_no_replay", beat_cnt, b0);
        check("t1_idle_valid", OVALID, 1'b0);

        // ---- 2. back-to-back words ----
        b0 = beat_cnt; p0 = pop_cnt; ip0 = idle_pop_cnt;
        first_beat_cyc = -1;
        push_word(160'h1A1A1A15_1A1A1A14_1A1A1A13_1A1A1A12_1A1A1A11);
        push_word(160'h2B2B2B25_2B2B2B24_2B2B2B23_2B2B2B22_2B2B2B21);
        push_word(160'h3C3C3C35_3C3C3C34_3C3C3C33_3C3C3C32_3C3C3C31);
        wait_beats(b0 + 15, 60);
        check("t2_pops", pop_cnt - p0, 3);
        check("t2_idle_pops", idle_pop_cnt - ip0, 1);
        check("t2_contig", last_beat_cyc - first_beat_cyc, 14);
        idle_cycles(2);
        check("t2_cnt", WORD_CNT, 3);
        check("t2_exp_empty", exp_q.size(), 0);

        // ---- 3. backpressure 1,0,0 ----
        b0 = beat_cnt; p0 = pop_cnt;
        push_word(160'h44444405_44444404_44444403_44444402_44444401);
        push_word(160'h55555505_55555504_55555503_55555502_55555501);
        t = 0;
        while (beat_cnt < b0 + 10 && t < 200) begin
            OREADY = (t % 3 == 0);
            @(posedge RCLK); #1;
            t++;
        end
        OREADY = 1'b1;
        if (beat_cnt < b0 + 10) check("t3_timeout", beat_cnt, b0 + 10);
        idle_cycles(2);
        check("t3_pops", pop_cnt - p0, 2);
        check("t3_beats", beat_cnt - b0, 10);
        check("t3_cnt", WORD_CNT, 5);

        // ---- 4. empty FIFO ----
        for (int i = 0; i < 20; i++) begin
            @(negedge RCLK);
            check("t4_rinc", RINC, 1'b0);
            check("t4_ovalid", OVALID, 1'b0);
        end
        @(posedge RCLK); #1;
        b0 = beat_cnt; p0 = pop_cnt;
        push_word(160'h77000005_77000004_77000003_77000002_77000001);
        wait_beats(b0 + 5, 40);
        idle_cycles(5);
        check("t4_pops", pop_cnt - p0, 1);
        check("t4_beats", beat_cnt - b0, 5);
        check("t4_cnt", WORD_CNT, 6);

        // ---- 5. EN drop mid-word ----
        b0 = beat_cnt; p0 = pop_cnt;
        push_word(160'h88888885_88888884_88888883_88888882_88888881);
        push_word(160'h99999995_99999994_99999993_99999992_99999991);
        push_word(160'hAAAAAAA5_AAAAAAA4_AAAAAAA3_AAAAAAA2_AAAAAAA1);
        wait_beats(b0 + 1, 20);
        #1;
        EN = 1'b0;
        idle_cycles(12);
        check("t5_pops", pop_cnt - p0, 1);
        check("t5_beats", beat_cnt - b0, 5);
        check("t5_idle", OVALID, 1'b0);
        check("t5_cnt", WORD_CNT, 7);
        EN = 1'b1;
        wait_beats(b0 + 15, 60);
        idle_cycles(2);
        check("t5_pops_all", pop_cnt - p0, 3);
        check("t5_cnt_all", WORD_CNT, 9);
        check("t5_exp_empty", exp_q.size(), 0);

        // ---- 6. counter wrap on a 4-bit instance ----
        @(posedge RCLK); #1;
        en2 = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            t = 0;
            @(negedge RCLK);
            while (!rinc2 && t < 20) begin
                @(negedge RCLK);
                t++;
            end
            if (!rinc2) check("wrap_pop_timeout", rinc2, 1'b1);
            @(posedge RCLK); #1;
            if (k == 16) en2 = 1'b0;
            check("wrap_cnt", cnt2, k % 16);
        end
        idle_cycles(10);
        check("wrap_final_cnt", cnt2, 0);
        check("wrap_final_idle", ovalid2, 1'b0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_read_unpacker.md
Name: fifo_read_unpacker

Overview:
Read-side consumer for the 160-bit async FIFO, clocked in the read domain. It pops whole FIFO words through the RDATA/REMPTY/RINC interface and serialises each word into narrower beats on a valid/ready stream for downstream logic. It also keeps a running count of words consumed, for bring-up and debug.

Parameters:
DWIDTH, 160, FIFO word width; must be an integer multiple of OWIDTH
OWIDTH, 32, output beat width
BEATS, DWIDTH/OWIDTH (5), beats per word; derived, not overridden
CWIDTH, 16, width of the consumed-word counter

Ports:
RCLK  input  1  read-domain clock; all state updates on the rising edge
RRST_n  input  1  reset, asynchronous assert, active-low
RDATA  input  DWIDTH  FIFO read data; show-ahead, valid whenever REMPTY=0
REMPTY  input  1  FIFO empty flag, synchronous to RCLK
RINC  output  1  FIFO pop strobe; combinational; one word popped per RCLK edge while high
EN  input  1  load enable; when 0, no new word is popped, and a word in progress still completes
ODATA  output  OWIDTH  current beat
OVALID  output  1  ODATA is valid
OREADY  input  1  downstream accepts the beat on an edge where OVALID=1 and OREADY=1
OLAST  output  1  high with the final beat of each word
WORD_CNT  output  CWIDTH  count of words popped since reset; wraps modulo 2^CWIDTH

Behaviour:
- Reset (RRST_n=0, asynchronous): buffer cleared, beat index=0, OVALID=0, OLAST=0, ODATA=0, WORD_CNT=0, state=IDLE.
  - RINC is forced to 0 while RRST_n=0.
  - Reset mid-word discards the remaining beats; nothing is replayed after release.
- States: IDLE (buffer empty) and SEND (buffer holds a word, beats pending).
- Load condition: load = EN & ~REMPTY & (state==IDLE | (OVALID & OREADY & OLAST)).
  - RINC = load.
  - On the edge where load=1: buffer <= RDATA, beat index <= 0, state <= SEND, WORD_CNT <= WORD_CNT+1.
- IDLE -> SEND on load.
  - Latency: the first beat is presented on OVALID in the cycle after the edge that captured the word.
- SEND:
  - ODATA = buffer[idx*OWIDTH +: OWIDTH]; beats are sent LSB slice first.
  - OVALID=1.
  - OLAST = (idx==BEATS-1).
- Handshake rules:
  - On OVALID & OREADY with OLAST=0: idx increments.
  - While OREADY=0: ODATA, OLAST and idx are held stable. OVALID never drops until the beat is accepted.
- Final beat accepted (OLAST & OREADY):
  - If load is also true that cycle: reload back-to-back (SEND -> SEND, idx=0, next word). This gives zero-bubble throughput of 1 beat/cycle.
  - Otherwise: state <= IDLE, OVALID <= 0.
- Empty FIFO: when REMPTY=1, RINC stays 0. The block never pops an empty FIFO, and REMPTY is never ignored.
- EN deasserted mid-word: the current word drains fully, then the block goes to IDLE.
- OREADY held low indefinitely: the block stalls; no pops occur, so FIFO backpressure propagates naturally.
- WORD_CNT wrap: 0xFFFF + 1 -> 0x0000, with no flag raised.
- Outputs ODATA, OVALID, OLAST and WORD_CNT are registered or derived from registers only. RINC is the only combinational output.
- Sizing: idx is sized to ceil(log2(BEATS)); the BEATS-1 compare wraps idx to 0 on reload.

Test Plan:
1. Reset mid-word:
   - Stimulus: hold RRST_n=0 with REMPTY=0, release, set EN=1, OREADY=1, RDATA=160'h...0005_0000_0004_0000_0003_0000_0002_0000_0001.
   - Required: no RINC pulse while RRST_n=0.
   - Required: one RINC pulse after release; ODATA sequence 1,2,3,4,5 on 5 consecutive cycles; OLAST only on 5; WORD_CNT=1.
   - Then assert RRST_n=0 after the second beat. Required: OVALID, OLAST and WORD_CNT go to 0 immediately (without a clock edge).
2. Back-to-back words:
   - Stimulus: REMPTY=0 for 3 words, OREADY=1 throughout.
   - Required: RINC high exactly on the cycles OLAST is accepted plus the initial load.
   - Required: 15 contiguous OVALID beats with no gaps; WORD_CNT=3.
3. Backpressure:
   - Stimulus: OREADY toggled 1,0,0,1,...
   - Required: ODATA and OLAST stable while OREADY=0; each beat transferred exactly once.
   - Required: RINC stays 0 until the last beat is accepted.
4. Empty handling:
   - Stimulus: REMPTY=1 with EN=1 for 20 cycles.
   - Required: RINC=0 and OVALID=0 throughout.
   - Then REMPTY drops for exactly one cycle. Required: exactly one pop and 5 beats.
5. EN drop:
   - Stimulus: EN=0 after the first beat of a word, with the FIFO non-empty.
   - Required: the remaining 4 beats are delivered, then IDLE; no further RINC until EN=1.
6. Counter wrap:
   - Stimulus: preload by popping 65536 words (or use CWIDTH=4 and 16 words).
   - Required: WORD_CNT returns to 0 after the final pop.
